// File: rtl/jtag_pkg.sv
// jtag_pkg: definitions shared by the JTAG host and the on-chip TAP.
//   - tap_state_e : IEEE 1149.1 TAP controller state encodings
//   - IR_*        : instruction register opcodes
//   - IDCODE      : device identification word returned by the TAP
//   - cmd_op_e    : host command opcodes
//   - ctl_state_e : host controller states
//   - TMS_*       : TMS preamble patterns, LSB is the first TCK slot
//   - eff_len()   : clamps a requested scan length into 1..max_len
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_EX2_DR   = 4'h0,
        TAP_EX1_DR   = 4'h1,
        TAP_SH_DR    = 4'h2,
        TAP_PAUSE_DR = 4'h3,
        TAP_SEL_IR   = 4'h4,
        TAP_UP_DR    = 4'h5,
        TAP_CAP_DR   = 4'h6,
        TAP_SEL_DR   = 4'h7,
        TAP_EX2_IR   = 4'h8,
        TAP_EX1_IR   = 4'h9,
        TAP_SH_IR    = 4'hA,
        TAP_PAUSE_IR = 4'hB,
        TAP_RTI      = 4'hC,
        TAP_UP_IR    = 4'hD,
        TAP_CAP_IR   = 4'hE,
        TAP_TLR      = 4'hF
    } tap_state_e;

    localparam logic [3:0]  IR_ABORT  = 4'b1000;
    localparam logic [3:0]  IR_IDCODE = 4'b1110;
    localparam logic [3:0]  IR_BYPASS = 4'b1111;
    localparam logic [31:0] IDCODE    = 32'h000F_AF01;

    typedef enum logic [1:0] {
        OP_RESET   = 2'd0,
        OP_IR_SCAN = 2'd1,
        OP_DR_SCAN = 2'd2,
        OP_IDLE    = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        CTL_IDLE,
        CTL_PRE,
        CTL_SHIFT,
        CTL_POST,
        CTL_RESP,
        CTL_TRST
    } ctl_state_e;

    // Preamble buffer holds reset (6 slots) plus the IR walk (4 slots).
    localparam int unsigned PRE_W      = 10;
    localparam logic [5:0]  TMS_RESET  = 6'b011111; // 1,1,1,1,1,0
    localparam logic [3:0]  TMS_IR_PRE = 4'b0011;   // 1,1,0,0
    localparam logic [2:0]  TMS_DR_PRE = 3'b001;    // 1,0,0

    function automatic int unsigned eff_len(input logic [5:0] len, input int unsigned max_len);
        if (len == 6'd0) return 1;
        if (32'(len) > max_len) return max_len;
        return 32'(len);
    endfunction

endpackage

// File: rtl/jtag_host_if.sv
// jtag_host_if: command/response port of the JTAG host.
//   cmd_valid/cmd_ready : command handshake
//   cmd_op/len/data     : operation, bit or TCK count, TDI bits (LSB first)
//   rsp_valid/rsp_ready : response handshake
//   rsp_data            : captured TDO bits
// master = command issuer, slave = jtag_host.
interface jtag_host_if #(parameter int unsigned MAX_LEN = 32);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [5:0]         cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [MAX_LEN-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: TCK generator. While i_en is high, o_tck toggles every
// CLK_DIV clk cycles, starting low. o_rise_tick / o_fall_tick are high in
// the cycle whose closing clk edge makes o_tck rise / fall, so the
// controller acts on the same edge as the pin changes.
// Ports: clk, rst_n (sync, active-low), i_en, o_tck, o_rise_tick, o_fall_tick.
module jtag_tck_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tck,
    output logic o_rise_tick,
    output logic o_fall_tick
);
    localparam int unsigned   CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tck;
    logic          w_wrap;

    assign w_wrap      = i_en && (r_cnt == CNT_MAX);
    assign o_rise_tick = w_wrap && !r_tck;
    assign o_fall_tick = w_wrap && r_tck;
    assign o_tck       = r_tck;

    always_ff @(posedge clk) begin
        if (!rst_n || !i_en) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/jtag_host.sv
// jtag_host: JTAG initiator. Takes RESET / IR_SCAN / DR_SCAN / IDLE commands,
// walks the TAP with the matching TMS sequences and returns captured TDO.
// Ports: clk, rst_n (sync, active-low), bus (jtag_host_if.slave),
//        tck_out, tms_out, tdi_out, tdo_in, tap_synced,
//        trst_n_out (only when JTAG_HOST_TRST_EN is defined).
// Optional feature macro: JTAG_HOST_TRST_EN.
module jtag_host
    import jtag_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned MAX_LEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    jtag_host_if.slave bus,
    output logic       tck_out,
    output logic       tms_out,
    output logic       tdi_out,
    input  logic       tdo_in,
    output logic       tap_synced
`ifdef JTAG_HOST_TRST_EN
    ,
    output logic       trst_n_out
`endif
);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned BW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    ctl_state_e         r_state, n_state;
    cmd_op_e            r_op, n_op;
    logic [LW-1:0]      r_len, n_len;
    logic [MAX_LEN-1:0] r_data, n_data, r_cap, n_cap, r_rsp_data, n_rsp_data;
    logic [PRE_W-1:0]   r_pre, n_pre;
    logic [3:0]         r_pn, n_pn, r_idx, n_idx;
    logic [BW-1:0]      r_bit, n_bit;
    logic               r_post, n_post;
    logic               r_tms, n_tms, r_tdi, n_tdi;
    logic               r_rsp_valid, n_rsp_valid, r_synced, n_synced, r_rdy_en;

    logic               w_en, w_tck, w_rise, w_fall, w_accept, w_scan, w_last_bit, w_done;
    cmd_op_e            w_op;
    logic [PRE_W-1:0]   w_pre;
    logic [3:0]         w_pn;

`ifdef JTAG_HOST_TRST_EN
    localparam int unsigned    TCW      = $clog2(4 * CLK_DIV);
    localparam logic [TCW-1:0] TRST_MAX = TCW'(4 * CLK_DIV - 1);
    logic           r_trst, n_trst;
    logic [TCW-1:0] r_tcnt, n_tcnt;
    assign trst_n_out = r_trst;
`endif

    assign w_en          = (r_state == CTL_PRE) || (r_state == CTL_SHIFT) || (r_state == CTL_POST);
    assign bus.cmd_ready = (r_state == CTL_IDLE) && !r_rsp_valid && r_rdy_en;
    assign w_accept      = bus.cmd_valid && bus.cmd_ready;
    assign w_op          = cmd_op_e'(bus.cmd_op);
    assign w_scan        = (r_op == OP_IR_SCAN) || (r_op == OP_DR_SCAN);
    assign w_last_bit    = (LW'(r_bit) == r_len - LW'(1));

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_en),
        .o_tck      (w_tck),
        .o_rise_tick(w_rise),
        .o_fall_tick(w_fall)
    );

    // The whole TMS preamble (reset prefix + Select/Capture walk) is built at
    // accept time into one slot vector so PRE is a single indexed phase.
    always_comb begin
        w_pre = '0;
        w_pn  = 4'd0;
        if (w_op == OP_RESET || !r_synced) begin
            w_pre[5:0] = TMS_RESET;
            w_pn       = 4'd6;
        end
        if (w_op == OP_IR_SCAN) begin
            w_pre = w_pre | (PRE_W'(TMS_IR_PRE) << w_pn);
            w_pn  = w_pn + 4'd4;
        end else if (w_op == OP_DR_SCAN) begin
            w_pre = w_pre | (PRE_W'(TMS_DR_PRE) << w_pn);
            w_pn  = w_pn + 4'd3;
        end
    end

    // Next-state logic. TMS/TDI for a slot are registered on the edge that
    // starts it (accept edge or the previous TCK fall).
    always_comb begin
        n_state     = r_state;
        n_op        = r_op;
        n_len       = r_len;
        n_data      = r_data;
        n_cap       = r_cap;
        n_pre       = r_pre;
        n_pn        = r_pn;
        n_idx       = r_idx;
        n_bit       = r_bit;
        n_post      = r_post;
        n_tms       = r_tms;
        n_tdi       = r_tdi;
        n_rsp_valid = r_rsp_valid;
        n_rsp_data  = r_rsp_data;
        n_synced    = r_synced;
        w_done      = 1'b0;
`ifdef JTAG_HOST_TRST_EN
        n_trst      = 1'b1;
        n_tcnt      = r_tcnt;
`endif
        case (r_state)
            CTL_IDLE: begin
                if (w_accept) begin
                    n_op   = w_op;
                    n_len  = LW'(eff_len(bus.cmd_len, MAX_LEN));
                    n_data = bus.cmd_data;
                    n_cap  = '0;
                    n_pre  = w_pre;
                    n_pn   = w_pn;
                    n_idx  = 4'd0;
                    n_bit  = '0;
                    n_post = 1'b0;
                    n_tdi  = 1'b0;
                    if (w_pn != 4'd0) begin
                        n_state = CTL_PRE;
                        n_tms   = w_pre[0];
                    end else begin
                        n_state = CTL_SHIFT;
                        n_tms   = 1'b0;
                    end
`ifdef JTAG_HOST_TRST_EN
                    if (w_op == OP_RESET) begin
                        n_state = CTL_TRST;
                        n_tcnt  = '0;
                        n_trst  = 1'b0;
                        n_tms   = 1'b1;
                    end
`endif
                end
            end
`ifdef JTAG_HOST_TRST_EN
            CTL_TRST: begin
                if (r_tcnt == TRST_MAX) begin
                    n_state = CTL_PRE;
                    n_tms   = r_pre[0];
                end else begin
                    n_trst = 1'b0;
                    n_tcnt = r_tcnt + 1'b1;
                end
            end
`endif
            CTL_PRE: begin
                if (w_fall) begin
                    if (r_idx == r_pn - 4'd1) begin
                        if (r_op == OP_RESET) begin
                            w_done = 1'b1;
                        end else begin
                            n_state = CTL_SHIFT;
                            n_tms   = w_scan && (r_len == LW'(1));
                            n_tdi   = w_scan && r_data[0];
                        end
                    end else begin
                        n_idx = r_idx + 4'd1;
                        n_tms = r_pre[r_idx + 4'd1];
                    end
                end
            end
            CTL_SHIFT: begin
                if (w_rise && w_scan) n_cap[r_bit] = tdo_in;
                if (w_fall) begin
                    if (w_last_bit) begin
                        if (w_scan) begin
                            n_state = CTL_POST;
                            n_tms   = 1'b1;
                            n_tdi   = 1'b0;
                        end else begin
                            w_done = 1'b1;
                        end
                    end else begin
                        n_bit = r_bit + 1'b1;
                        n_tms = w_scan && (LW'(r_bit) + LW'(2) == r_len);
                        n_tdi = w_scan && r_data[r_bit + 1'b1];
                    end
                end
            end
            CTL_POST: begin
                if (w_fall) begin
                    if (!r_post) begin
                        n_post = 1'b1;
                        n_tms  = 1'b0;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            CTL_RESP: begin
                if (bus.rsp_ready) begin
                    n_rsp_valid = 1'b0;
                    n_state     = CTL_IDLE;
                end
            end
            default: n_state = CTL_IDLE;
        endcase

        if (w_done) begin
            n_state     = CTL_RESP;
            n_rsp_valid = 1'b1;
            n_rsp_data  = w_scan ? r_cap : '0;
            n_synced    = 1'b1;
            n_tms       = 1'b0;
            n_tdi       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= CTL_IDLE;
            r_op        <= OP_RESET;
            r_len       <= '0;
            r_data      <= '0;
            r_cap       <= '0;
            r_pre       <= '0;
            r_pn        <= '0;
            r_idx       <= '0;
            r_bit       <= '0;
            r_post      <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_synced    <= 1'b0;
            r_rdy_en    <= 1'b0;
`ifdef JTAG_HOST_TRST_EN
            r_trst      <= 1'b0;
            r_tcnt      <= '0;
`endif
        end else begin
            r_state     <= n_state;
            r_op        <= n_op;
            r_len       <= n_len;
            r_data      <= n_data;
            r_cap       <= n_cap;
            r_pre       <= n_pre;
            r_pn        <= n_pn;
            r_idx       <= n_idx;
            r_bit       <= n_bit;
            r_post      <= n_post;
            r_tms       <= n_tms;
            r_tdi       <= n_tdi;
            r_rsp_valid <= n_rsp_valid;
            r_rsp_data  <= n_rsp_data;
            r_synced    <= n_synced;
            r_rdy_en    <= 1'b1;
`ifdef JTAG_HOST_TRST_EN
            r_trst      <= n_trst;
            r_tcnt      <= n_tcnt;
`endif
        end
    end

    assign tck_out       = w_tck;
    assign tms_out       = r_tms;
    assign tdi_out       = r_tdi;
    assign tap_synced    = r_synced;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_jtag_host.sv
// tb_jtag_host: drives jtag_host (CLK_DIV=2) against a small behavioural
// TAP target (IDCODE / BYPASS, IR capture 4'b0101) with a vector table,
// then hand-written sequences for reset, backpressure and reset mid-shift.
module tb_jtag_host;
    import jtag_pkg::*;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned MAX_LEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic tck_out, tms_out, tdi_out, tdo_in, tap_synced;
    logic force_tdo = 1'b0;
`ifdef JTAG_HOST_TRST_EN
    logic trst_n_out;
`endif

    int total = 0;
    int bad   = 0;
    int tck_edges = 0;

    jtag_host_if #(.MAX_LEN(MAX_LEN)) bus ();

    jtag_host #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .tck_out   (tck_out),
        .tms_out   (tms_out),
        .tdi_out   (tdi_out),
        .tdo_in    (tdo_in),
        .tap_synced(tap_synced)
`ifdef JTAG_HOST_TRST_EN
        ,
        .trst_n_out(trst_n_out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge tck_out) tck_edges++;

    // ---------------- behavioural TAP target ----------------
    tap_state_e  m_state = TAP_TLR;
    logic [3:0]  m_ir    = IR_IDCODE;
    logic [3:0]  m_ir_sr = 4'h0;
    logic [31:0] m_dr_sr = 32'h0;
    logic        m_byp   = 1'b0;
    logic        m_tdo   = 1'b0;

    assign tdo_in = force_tdo ? 1'b1 : m_tdo;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        case (s)
            TAP_TLR:      return tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      return tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   return tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   return tms ? TAP_EX1_DR   : TAP_SH_DR;
            TAP_SH_DR:    return tms ? TAP_EX1_DR   : TAP_SH_DR;
            TAP_EX1_DR:   return tms ? TAP_UP_DR    : TAP_PAUSE_DR;
            TAP_PAUSE_DR: return tms ? TAP_EX2_DR   : TAP_PAUSE_DR;
            TAP_EX2_DR:   return tms ? TAP_UP_DR    : TAP_SH_DR;
            TAP_UP_DR:    return tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   return tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   return tms ? TAP_EX1_IR   : TAP_SH_IR;
            TAP_SH_IR:    return tms ? TAP_EX1_IR   : TAP_SH_IR;
            TAP_EX1_IR:   return tms ? TAP_UP_IR    : TAP_PAUSE_IR;
            TAP_PAUSE_IR: return tms ? TAP_EX2_IR   : TAP_PAUSE_IR;
            TAP_EX2_IR:   return tms ? TAP_UP_IR    : TAP_SH_IR;
            TAP_UP_IR:    return tms ? TAP_SEL_DR   : TAP_RTI;
            default:      return TAP_TLR;
        endcase
    endfunction

    always @(posedge tck_out) begin
        case (m_state)
            TAP_TLR:    m_ir <= IR_IDCODE;
            TAP_CAP_IR: m_ir_sr <= 4'b0101;
            TAP_SH_IR:  m_ir_sr <= {tdi_out, m_ir_sr[3:1]};
            TAP_UP_IR:  m_ir <= m_ir_sr;
            TAP_CAP_DR: begin
                m_byp   <= 1'b0;
                m_dr_sr <= IDCODE;
            end
            TAP_SH_DR: begin
                if (m_ir == IR_BYPASS) m_byp <= tdi_out;
                else m_dr_sr <= {tdi_out, m_dr_sr[31:1]};
            end
            default: ;
        endcase
        m_state <= tap_next(m_state, tms_out);
    end

    always @(negedge tck_out) begin
        if (m_state == TAP_SH_IR)      m_tdo <= m_ir_sr[0];
        else if (m_state == TAP_SH_DR) m_tdo <= (m_ir == IR_BYPASS) ? m_byp : m_dr_sr[0];
        else                           m_tdo <= 1'b0;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one command, wait for the response, consume it.
    task automatic do_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                          output logic [31:0] rsp, output int tcks, output int lat);
        int k;
        int t0;
        k = 0;
        while (!bus.cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        bus.cmd_data  = data;
        bus.cmd_valid = 1'b1;
        t0 = tck_edges;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        k = 0;
        while (!bus.rsp_valid && k < 3000) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        chk("rsp_arrived", {31'b0, bus.rsp_valid}, 32'd1);
        chk("cmd_ready_while_rsp", {31'b0, bus.cmd_ready}, 32'd0);
        lat  = k + 1;
        tcks = tck_edges - t0;
        rsp  = bus.rsp_data;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_cleared", {31'b0, bus.rsp_valid}, 32'd0);
        chk("cmd_ready_back", {31'b0, bus.cmd_ready}, 32'd1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  len;
        logic [31:0] data;
        logic        force1;
        logic [31:0] exp_rsp;
        int          exp_tck;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] rsp;
        logic [31:0] snap;
        logic        stable;
        int          tcks, lat, t0, k;

        vecs[0]  = '{OP_DR_SCAN, 6'd8,  32'h0,         1'b0, 32'h0000_0001, 19};
        vecs[1]  = '{OP_RESET,   6'd0,  32'h0,         1'b0, 32'h0,          6};
        vecs[2]  = '{OP_IR_SCAN, 6'd4,  32'hE,         1'b0, 32'h5,         10};
        vecs[3]  = '{OP_DR_SCAN, 6'd32, 32'h0,         1'b0, 32'h000F_AF01, 37};
        vecs[4]  = '{OP_IR_SCAN, 6'd4,  32'hF,         1'b0, 32'h5,         10};
        vecs[5]  = '{OP_DR_SCAN, 6'd8,  32'hA5,        1'b0, 32'h4A,        13};
        vecs[6]  = '{OP_IDLE,    6'd7,  32'hFFFF_FFFF, 1'b0, 32'h0,          7};
        vecs[7]  = '{OP_IDLE,    6'd0,  32'h0,         1'b0, 32'h0,          1};
        vecs[8]  = '{OP_DR_SCAN, 6'd5,  32'h0,         1'b1, 32'h1F,        10};
        vecs[9]  = '{OP_DR_SCAN, 6'd0,  32'h0,         1'b1, 32'h1,          6};
        vecs[10] = '{OP_DR_SCAN, 6'd40, 32'h0,         1'b1, 32'hFFFF_FFFF, 37};
        vecs[11] = '{OP_IR_SCAN, 6'd4,  32'hE,         1'b0, 32'h5,         10};
        vecs[12] = '{OP_DR_SCAN, 6'd32, 32'hDEAD_BEEF, 1'b0, 32'h000F_AF01, 37};
        vecs[13] = '{OP_DR_SCAN, 6'd16, 32'hAAAA,      1'b0, 32'h0000_AF01, 21};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_len   = 6'd0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tck", {31'b0, tck_out}, 32'd0);
        chk("rst_tms", {31'b0, tms_out}, 32'd1);
        chk("rst_tdi", {31'b0, tdi_out}, 32'd0);
        chk("rst_synced", {31'b0, tap_synced}, 32'd0);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_rst", {31'b0, bus.cmd_ready}, 32'd1);

        // Vector table
        for (int unsigned i = 0; i < 14; i++) begin
            force_tdo = vecs[i].force1;
            do_cmd(vecs[i].op, vecs[i].len, vecs[i].data, rsp, tcks, lat);
            chk($sformatf("v%0d_rsp", i), rsp, vecs[i].exp_rsp);
            chk($sformatf("v%0d_tcks", i), tcks, vecs[i].exp_tck);
            chk($sformatf("v%0d_lat", i), lat, 2 * CLK_DIV * vecs[i].exp_tck + 1);
            chk($sformatf("v%0d_synced", i), {31'b0, tap_synced}, 32'd1);
            chk($sformatf("v%0d_tap_rti", i), {28'b0, m_state}, {28'b0, TAP_RTI});
        end
        force_tdo = 1'b0;

        // Backpressure: response held, stray command ignored
        bus.cmd_op = OP_DR_SCAN; bus.cmd_len = 6'd4; bus.cmd_data = '0;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        k = 0;
        while (!bus.rsp_valid && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("bp_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        snap   = bus.rsp_data;
        stable = 1'b1;
        bus.cmd_op = OP_IDLE; bus.cmd_len = 6'd5;
        bus.cmd_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_data !== snap || bus.cmd_ready) stable = 1'b0;
        end
        chk("bp_hold", {31'b0, stable}, 32'd1);
        chk("bp_data", snap, 32'h1);
        bus.cmd_valid = 1'b0;
        t0 = tck_edges;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_queued_tck", tck_edges - t0, 32'd0);
        chk("no_queued_rsp", {31'b0, bus.rsp_valid}, 32'd0);

        // Reset in the middle of a long shift
        bus.cmd_op = OP_DR_SCAN; bus.cmd_len = 6'd32; bus.cmd_data = 32'hFFFF_FFFF;
        bus.cmd_valid = 1'b1;
        t0 = tck_edges;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        k = 0;
        while ((tck_edges - t0) < 15 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reached_shift", {31'b0, (tck_edges - t0) >= 15}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_tck", {31'b0, tck_out}, 32'd0);
        chk("mid_rst_tms", {31'b0, tms_out}, 32'd1);
        chk("mid_rst_synced", {31'b0, tap_synced}, 32'd0);
        chk("mid_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_cmd(OP_DR_SCAN, 6'd8, 32'h0, rsp, tcks, lat);
        chk("post_rst_tcks", tcks, 32'd19);
        chk("post_rst_rsp", rsp, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/jtag_host.md
# jtag_host

Probe-side JTAG initiator that drives TCK/TMS/TDI into an on-chip or off-chip TAP and samples TDO. It accepts high-level commands (TAP reset, IR scan, DR scan, idle clocks) on a valid/ready port, walks the IEEE 1149.1 state machine with the correct TMS sequences, and returns captured TDO bits on a response port. It lets the system clock domain exercise the existing `jtag` TAP in loopback or drive an external target.

## Interface
- `CLK_DIV`, default 4: half-period of TCK in `clk` cycles (≥1); TCK period = 2·CLK_DIV cycles.
- `MAX_LEN`, default 32: widest scan in bits; sets data width.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake; transfer when both high.
- `cmd_op` in 2: 0 RESET, 1 IR_SCAN, 2 DR_SCAN, 3 IDLE.
- `cmd_len` in 6: bit count (scans) or TCK count (IDLE).
- `cmd_data` in MAX_LEN: TDI bits, LSB shifted first.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_data` out MAX_LEN: captured TDO, bit i = i-th shifted bit; bits ≥ len are 0.
- `tck_out`, `tms_out`, `tdi_out` out 1: JTAG pins. `tdo_in` in 1: JTAG TDO.
- `tap_synced` out 1: host mirror known to equal target TAP state.

## Operation
- Reset values: `cmd_ready`=0 first cycle then 1, `rsp_valid`=0, `rsp_data`=0, `tck_out`=0, `tms_out`=1, `tdi_out`=0, `tap_synced`=0.
- `cmd_ready` = controller IDLE && !`rsp_valid`.
- Length: `cmd_len` 0 treated as 1; >MAX_LEN saturates to MAX_LEN.
- RESET: TMS 1,1,1,1,1,0 → target in RunTestIdle; sets `tap_synced`. Response with `rsp_data`=0.
- IR_SCAN from RunTestIdle: TMS 1,1,0,0 (SelectDR, SelectIR, CaptureIR, ShiftIR); len shift bits, TMS=0 except last bit TMS=1 (→Exit1IR); then TMS 1 (UpdateIR), 0 (RunTestIdle). len+6 TCKs.
- DR_SCAN: TMS 1,0,0; len shift bits as above; then 1,0. len+5 TCKs.
- IDLE: len TCKs with TMS=0, TDI=0; response data 0.
- Scan or IDLE issued while `tap_synced`=0: RESET sequence automatically prepended; one response only.
- TDI = `cmd_data[i]` during shift bit i, 0 elsewhere. TDO captured only in shift bits.
- Controller states: IDLE, PRE (TMS preamble), SHIFT, POST (exit/update/return), RESP.

## Timing
- Bit slot: TMS/TDI change on same cycle `tck_out` falls (or on acceptance+1 for first slot); `tck_out` rises CLK_DIV cycles later, `tdo_in` sampled that cycle; falls CLK_DIV cycles after rise.
- `tck_out` low whenever idle; no glitches or shortened phases.
- `rsp_valid` rises CLK_DIV cycles after last TCK rise (falling edge of last slot), holds with stable data until `rsp_ready`; `cmd_ready` returns next cycle.
- Latency accept→`rsp_valid`: 2·CLK_DIV·N + 1 cycles, N = TCK count.
- `rst_n` low mid-scan: pins return to reset values next edge, partial result discarded, `tap_synced`=0.
- `cmd_valid` while `cmd_ready`=0: ignored, no queueing.

## Configuration
- `JTAG_HOST_TRST_EN`: adds output `trst_n_out`; RESET op additionally drives it low for 2 TCK periods (TCK idle) before the TMS sequence; reset value 0, released to 1 first cycle after `rst_n` deasserts. Without it: port absent, RESET uses TMS only.

## Structure
- Shared package `jtag_pkg`: TAP state encodings (shared with `jtag`), IR opcodes (Abort 4'b1000, IdCode 4'b1110, Bypass 4'b1111), IDCODE constant, `cmd_op` encodings.
- Sub-module `jtag_tck_gen`: CLK_DIV counter producing `tck_out` plus one-cycle `rise_tick`/`fall_tick` strobes, enabled by controller.

## Test plan
- Loopback to `jtag`, CLK_DIV=2: RESET → 6 TCKs, `tap_synced`=1, `rsp_data`=0, TAP in RunTestIdle.
- IR_SCAN len 4 data 4'b1110 then DR_SCAN len 32 data 0 → `rsp_data`=32'h000FAF01, 37 TCKs for DR.
- DR_SCAN len 8 before any RESET → 6-TCK reset prepended, single response, total 19 TCKs.
- `tdo_in` tied 1, DR_SCAN len 5 → `rsp_data`=5'b11111, upper bits 0; `cmd_len`=0 → 1 bit, `rsp_data`=1.
- `rsp_ready` low 10 cycles → `rsp_valid`/`rsp_data` stable, `cmd_ready`=0; `rst_n` pulse mid-shift → `tck_out`=0, `tms_out`=1, `tap_synced`=0.
- `JTAG_HOST_TRST_EN` defined: RESET → `trst_n_out` low 4·CLK_DIV cycles, then TMS sequence.
